// File: rtl/sprite_texel_gen_pkg.sv
// Shared definitions for the sprite texel address stage: texel coordinate
// width, minimum on-screen sprite size, controller state encoding and the
// step-width helper.
package sprite_texel_gen_pkg;

    // Texel coordinates address a 64x64 sprite ROM.
    localparam int TEXEL_W  = 6;
    // Smallest non-zero sprite size; keeps 65536/size inside 16 bits.
    localparam int SIZE_MIN = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ARMED  = 2'd2
    } state_e;

    // Step is Q6.frac_bits: a whole texel index plus the fraction.
    function automatic int step_w(input int frac_bits);
        return TEXEL_W + frac_bits;
    endfunction

endpackage

// File: rtl/sprite_step_div.sv
// Sequential restoring divider computing 2^Q_W / divisor_i, one quotient
// bit per clock (Q_W+1 clocks after start_i). done_o and quot_o are
// combinational on the final iteration so the caller can capture the
// quotient on the same edge that retires the last bit.
module sprite_step_div #(
    parameter int DIVISOR_W = 10,
    parameter int Q_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [Q_W-1:0]       quot_o
);

    localparam int DVD_W = Q_W + 1;
    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0]     dvd_q, dvd_d, dvd_shift;
    logic [REM_W-1:0]     rem_q, rem_d, rem_sh;
    logic [DIVISOR_W-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 q_bit;

    // One restoring step per clock: shift in the next dividend bit,
    // subtract the divisor when it fits, shift the quotient bit in at LSB.
    always_comb begin
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        rem_sh    = {rem_q[REM_W-2:0], dvd_q[DVD_W-1]};
        q_bit     = (rem_sh >= {1'b0, dsr_q});
        dvd_shift = {dvd_q[DVD_W-2:0], q_bit};
        if (start_i) begin
            dvd_d  = DVD_W'(1) << Q_W;
            rem_d  = '0;
            dsr_d  = divisor_i;
            cnt_d  = CNT_W'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = q_bit ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
            dvd_d = dvd_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers; reset abandons any division in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    assign quot_o = dvd_shift[Q_W-1:0];

endmodule

// File: rtl/sprite_texel_gen.sv
// Sprite texel address stage: maps the raster position onto (col, row) of
// a 64x64 sprite ROM for one square, screen-space scaled sprite. The texel
// step 64/size is produced once per load by sprite_step_div; per-pixel and
// per-line stepping uses accumulators. Optional horizontal mirroring is
// built only when SPRITE_HFLIP_EN is defined.
//
// Handshake: a setup is taken on any clock where load_valid && load_ready;
// load_ready is low only while the step division is running.
module sprite_texel_gen
    import sprite_texel_gen_pkg::*;
#(
    parameter int H_BITS    = 10,
    parameter int V_BITS    = 10,
    parameter int SIZE_BITS = 10,
    parameter int FRAC_BITS = 10,
    parameter int H_LAST    = 799
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [H_BITS-1:0]    hpos,
    input  logic [V_BITS-1:0]    vpos,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [H_BITS-1:0]    sprite_x,
    input  logic [V_BITS-1:0]    sprite_y,
    input  logic [SIZE_BITS-1:0] sprite_size,
    input  logic                 sprite_flip,
    output logic [TEXEL_W-1:0]   col,
    output logic [TEXEL_W-1:0]   row,
    output logic                 texel_valid
);

    localparam int STEP_W = step_w(FRAC_BITS);

    state_e                state_q, state_d;
    logic [H_BITS-1:0]     x_q;
    logic [V_BITS-1:0]     y_q;
    logic [SIZE_BITS-1:0]  size_q, size_cl;
    logic [STEP_W-1:0]     step_q, col_acc_q, col_acc_d, row_acc_q, row_acc_d;
    logic [TEXEL_W-1:0]    col_q, row_q, tex_col;
    logic                  valid_q, valid_d;
    logic                  accept, armed, h_in, v_in, line_end, row_zero;
    logic [H_BITS:0]       x_end;
    logic [V_BITS:0]       y_end;
    logic                  div_start, div_busy, div_done;
    logic [STEP_W-1:0]     div_quot;
    logic                  unused_ok;
`ifdef SPRITE_HFLIP_EN
    logic                  flip_q;
`endif

    assign load_ready = (state_q != ST_DIVIDE);
    assign accept     = load_valid && load_ready;
    assign armed      = (state_q == ST_ARMED);
    assign size_cl    = (sprite_size != '0 && sprite_size < SIZE_BITS'(SIZE_MIN))
                        ? SIZE_BITS'(SIZE_MIN) : sprite_size;
    assign div_start  = accept && (size_cl != '0);
    assign unused_ok  = &{1'b0, div_busy, sprite_flip};

    sprite_step_div #(
        .DIVISOR_W (SIZE_BITS),
        .Q_W       (STEP_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (div_start),
        .divisor_i (size_cl),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quot_o    (div_quot)
    );

    // Controller next state: a non-zero load always restarts the division.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (div_start) state_d = ST_DIVIDE;
            ST_DIVIDE: if (div_done)  state_d = ST_ARMED;
            ST_ARMED:  if (accept)    state_d = div_start ? ST_DIVIDE : ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Sprite window tests and accumulator/output next values.
    always_comb begin
        x_end     = {1'b0, x_q} + (H_BITS+1)'(size_q);
        y_end     = {1'b0, y_q} + (V_BITS+1)'(size_q);
        h_in      = ({1'b0, hpos} >= {1'b0, x_q}) && ({1'b0, hpos} < x_end);
        v_in      = ({1'b0, vpos} >= {1'b0, y_q}) && ({1'b0, vpos} < y_end);
        line_end  = (hpos == H_BITS'(H_LAST));
        // Restart the row count on the line ending just above the sprite;
        // a sprite at y == 0 restarts on any line ending outside it.
        row_zero  = (({1'b0, vpos} + (V_BITS+1)'(1)) == {1'b0, y_q})
                    || ((y_q == '0) && !v_in);
        col_acc_d = col_acc_q;
        row_acc_d = row_acc_q;
        if (accept) begin
            col_acc_d = '0;
            row_acc_d = '0;
        end else if (armed) begin
            if (hpos == x_q) begin
                col_acc_d = '0;
            end else if (h_in) begin
                col_acc_d = col_acc_q + step_q;
            end
            if (line_end) begin
                if (row_zero) begin
                    row_acc_d = '0;
                end else if (v_in) begin
                    row_acc_d = row_acc_q + step_q;
                end
            end
        end
        tex_col = col_acc_d[FRAC_BITS+TEXEL_W-1:FRAC_BITS];
`ifdef SPRITE_HFLIP_EN
        if (flip_q) begin
            tex_col = TEXEL_W'(63) - tex_col;
        end
`endif
        valid_d = armed && h_in && v_in && !accept;
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Setup latches, step capture, accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            size_q    <= '0;
            step_q    <= '0;
            col_acc_q <= '0;
            row_acc_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (accept) begin
                x_q    <= sprite_x;
                y_q    <= sprite_y;
                size_q <= size_cl;
            end
            if (div_done) begin
                step_q <= div_quot;
            end
            col_acc_q <= col_acc_d;
            row_acc_q <= row_acc_d;
            valid_q   <= valid_d;
            if (valid_d) begin
                col_q <= tex_col;
                row_q <= row_acc_q[FRAC_BITS+TEXEL_W-1:FRAC_BITS];
            end
        end
    end

`ifdef SPRITE_HFLIP_EN
    // Mirror request is latched with the rest of the setup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flip_q <= 1'b0;
        end else if (accept) begin
            flip_q <= sprite_flip;
        end
    end
`endif

    assign col         = col_q;
    assign row         = row_q;
    assign texel_valid = valid_q;

endmodule
